motor_startup_sequencer: RTL and testbench

Parametrised successor to the BLDC motor control unit. It sequences motor start-up through rotor vector alignment, encoder zeroing and normal run. It adds start/stop control, fault abort with latched fault state, and exact-period control-loop and filter strobes with a configurable filter divider. It sits between the host/command logic and the commutation, encoder and velocity-controller blocks.

---
 rtl/motor_ctrl_pkg.sv | 17 +
 rtl/loop_pulse_gen.sv | 52 +++++
 rtl/motor_startup_sequencer.sv | 108 ++++++++++
 tb/tb_motor_startup_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and default constants for the motor start-up sequencer.
package motor_ctrl_pkg;

  // Encodings are visible on state_out and must stay fixed.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAlign = 3'd1,
    StZero  = 3'd2,
    StRun   = 3'd3,
    StFault = 3'd4
  } mcu_state_t;

  localparam int unsigned ALIGN_TICKS_DEF = 100_000_000;
  localparam int unsigned ZERO_TICKS_DEF  = 5_000_000;
  localparam int unsigned LOOP_PERIOD_DEF = 50_000;

endpackage

// File: rtl/loop_pulse_gen.sv
// Control-loop and filter strobe generator.
// Emits a one-cycle control_loop_pulse every LOOP_PERIOD cycles and a coincident
// filter_pulse on every FILTER_DIV-th loop pulse. While gate is low both counters
// are held at 0 and the strobes are suppressed, so the phase restarts when gate rises.
module loop_pulse_gen
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned LOOP_PERIOD = LOOP_PERIOD_DEF,
  parameter int unsigned FILTER_DIV  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic gate,
  output logic control_loop_pulse,
  output logic filter_pulse
);

  localparam int unsigned CntW = $clog2(LOOP_PERIOD);
  localparam int unsigned DivW = $clog2(FILTER_DIV) + 1;

  logic [CntW-1:0] cnt_q;
  logic [DivW-1:0] div_q;
  logic            pulse_q;

  // Period counter, registered strobe and filter divider advancing on each strobe.
  always_ff @(posedge clk) begin
    if (reset || !gate) begin
      cnt_q   <= '0;
      div_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= (cnt_q == '0);
      if (cnt_q == CntW'(LOOP_PERIOD - 1)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (pulse_q) begin
        if (div_q == DivW'(FILTER_DIV - 1)) begin
          div_q <= '0;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  // Gate also masks the outputs so strobes stop in the cycle the gate drops.
  assign control_loop_pulse = pulse_q & gate;
  assign filter_pulse       = pulse_q & gate & (div_q == '0);

endmodule

// File: rtl/motor_startup_sequencer.sv
// Motor start-up sequencer: IDLE -> ALIGN -> ZERO -> RUN with stop and latched fault.
// Optional build macro MCU_LOOP_GATE_EN: when defined, loop/filter strobes run only
// in RUN and restart their phase on each RUN entry; otherwise they free-run from reset.
module motor_startup_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned ALIGN_TICKS = ALIGN_TICKS_DEF,
  parameter int unsigned ZERO_TICKS  = ZERO_TICKS_DEF,
  parameter int unsigned DELAY_W     = 32,
  parameter int unsigned LOOP_PERIOD = LOOP_PERIOD_DEF,
  parameter int unsigned FILTER_DIV  = 1,
  parameter int unsigned AUTO_START  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       fault,
  input  logic       clear_fault,
  output logic       reset_encoder_count,
  output logic       apply_initial_commutation,
  output logic       controller_override,
  output logic       commutation_enable,
  output logic       control_loop_pulse,
  output logic       filter_pulse,
  output logic       running,
  output logic       fault_latched,
  output logic [2:0] state_out
);

  mcu_state_t         state_q;
  logic [DELAY_W-1:0] dly_q;
  logic               loop_gate;

  // Sequencer FSM; delay counter is loaded with N-1 on entry so each phase lasts N cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dly_q   <= '0;
    end else if (fault && (state_q != StFault)) begin
      state_q <= StFault;
    end else if (stop && ((state_q == StAlign) || (state_q == StZero) || (state_q == StRun))) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start || (AUTO_START != 0)) begin
            state_q <= StAlign;
            dly_q   <= DELAY_W'(ALIGN_TICKS - 1);
          end
        end
        StAlign: begin
          if (dly_q == '0) begin
            state_q <= StZero;
            dly_q   <= DELAY_W'(ZERO_TICKS - 1);
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        StZero: begin
          if (dly_q == '0) begin
            state_q <= StRun;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        StFault: begin
          if (clear_fault && !fault) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef MCU_LOOP_GATE_EN
  assign loop_gate = (state_q == StRun);
`else
  assign loop_gate = 1'b1;
`endif

  loop_pulse_gen #(
    .LOOP_PERIOD (LOOP_PERIOD),
    .FILTER_DIV  (FILTER_DIV)
  ) u_loop_pulse_gen (
    .clk                (clk),
    .reset              (reset),
    .gate               (loop_gate),
    .control_loop_pulse (control_loop_pulse),
    .filter_pulse       (filter_pulse)
  );

  // Drive outputs decode the registered state directly, so they track it with no lag.
  assign reset_encoder_count       = (state_q == StZero);
  assign apply_initial_commutation = (state_q == StAlign);
  assign controller_override       = (state_q == StAlign);
  assign commutation_enable        = (state_q == StAlign) || (state_q == StRun);
  assign running                   = (state_q == StRun);
  assign fault_latched             = (state_q == StFault);
  assign state_out                 = state_q;

endmodule

// File: tb/tb_motor_startup_sequencer.sv
// Self-checking bench for motor_startup_sequencer: vector table, hand-written
// strobe sequences and randomized stimulus against a dwell-time reference model.
module tb_motor_startup_sequencer;

  localparam int unsigned AT = 10;
  localparam int unsigned ZT = 4;
  localparam int unsigned LP = 8;
  localparam int unsigned FD = 3;

  logic       clk;
  logic       reset, start, stop, fault, clear_fault;
  logic       reset_encoder_count, apply_initial_commutation, controller_override;
  logic       commutation_enable, control_loop_pulse, filter_pulse, running, fault_latched;
  logic [2:0] state_out;

  int n_checks;
  int n_errors;

  // Reference model: phase number, cycles left in the timed phase, edges since strobe epoch.
  int m_state;
  int m_left;
  int m_edges;

  typedef struct {
    logic       rst, st, sp, flt, clr;
    int         cycles;
    logic [2:0] exp_state;
    logic       exp_comm;
    logic       exp_run;
  } vec_t;

  vec_t vecs[$];

  motor_startup_sequencer #(
    .ALIGN_TICKS (AT),
    .ZERO_TICKS  (ZT),
    .DELAY_W     (8),
    .LOOP_PERIOD (LP),
    .FILTER_DIV  (FD),
    .AUTO_START  (0)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .stop                      (stop),
    .fault                     (fault),
    .clear_fault               (clear_fault),
    .reset_encoder_count       (reset_encoder_count),
    .apply_initial_commutation (apply_initial_commutation),
    .controller_override       (controller_override),
    .commutation_enable        (commutation_enable),
    .control_loop_pulse        (control_loop_pulse),
    .filter_pulse              (filter_pulse),
    .running                   (running),
    .fault_latched             (fault_latched),
    .state_out                 (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int ns;
    int prev;
    prev = m_state;
    ns   = m_state;
    if (reset) begin
      ns      = 0;
      m_left  = 0;
      m_edges = 0;
    end else begin
      if (m_state != 4 && fault) ns = 4;
      else if (m_state >= 1 && m_state <= 3 && stop) ns = 0;
      else begin
        case (m_state)
          0: if (start) begin ns = 1; m_left = AT; end
          1: begin
            m_left--;
            if (m_left == 0) begin ns = 2; m_left = ZT; end
          end
          2: begin
            m_left--;
            if (m_left == 0) ns = 3;
          end
          4: if (clear_fault && !fault) ns = 0;
          default: ;
        endcase
      end
`ifdef MCU_LOOP_GATE_EN
      if (ns != 3 || prev != 3) m_edges = 0;
      else m_edges++;
`else
      m_edges++;
`endif
    end
    m_state = ns;
  endtask

  task automatic check_model();
    logic exp_p, exp_f;
    exp_p = (m_edges >= 1) && (((m_edges - 1) % LP) == 0);
    exp_f = (m_edges >= 1) && (((m_edges - 1) % (LP * FD)) == 0);
`ifdef MCU_LOOP_GATE_EN
    exp_p = exp_p && (m_state == 3);
    exp_f = exp_f && (m_state == 3);
`endif
    chk("m.state_out", state_out, 3'(m_state));
    chk("m.reset_encoder_count", {2'b0, reset_encoder_count}, {2'b0, m_state == 2});
    chk("m.apply_initial_commutation", {2'b0, apply_initial_commutation}, {2'b0, m_state == 1});
    chk("m.controller_override", {2'b0, controller_override}, {2'b0, m_state == 1});
    chk("m.commutation_enable", {2'b0, commutation_enable},
        {2'b0, (m_state == 1) || (m_state == 3)});
    chk("m.running", {2'b0, running}, {2'b0, m_state == 3});
    chk("m.fault_latched", {2'b0, fault_latched}, {2'b0, m_state == 4});
    chk("m.control_loop_pulse", {2'b0, control_loop_pulse}, {2'b0, exp_p});
    chk("m.filter_pulse", {2'b0, filter_pulse}, {2'b0, exp_f});
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic f,
                      input logic c);
    reset       = r;
    start       = s;
    stop        = p;
    fault       = f;
    clear_fault = c;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    m_state     = 0;
    m_left      = 0;
    m_edges     = 0;
    reset       = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    fault       = 1'b0;
    clear_fault = 1'b0;

    //                rst   st    sp    flt   clr  cyc st  comm  run
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  2, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  9, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  3, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 3, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 3, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  9, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  2, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  3, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  2, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  3, 0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].flt, vecs[i].clr);
      end
      chk($sformatf("vec%0d.state_out", i), state_out, vecs[i].exp_state);
      chk($sformatf("vec%0d.commutation_enable", i), {2'b0, commutation_enable},
          {2'b0, vecs[i].exp_comm});
      chk($sformatf("vec%0d.running", i), {2'b0, running}, {2'b0, vecs[i].exp_run});
    end

    // Strobe phase after reset release while idling.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      logic ep, ef;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MCU_LOOP_GATE_EN
      ep = 1'b0;
      ef = 1'b0;
`else
      ep = (k inside {1, 9, 17, 25, 33, 41, 49});
      ef = (k inside {1, 25, 49});
`endif
      chk($sformatf("seq.idle_loop_pulse k=%0d", k), {2'b0, control_loop_pulse}, {2'b0, ep});
      chk($sformatf("seq.idle_filter_pulse k=%0d", k), {2'b0, filter_pulse}, {2'b0, ef});
    end

`ifdef MCU_LOOP_GATE_EN
    // Strobes start one cycle after RUN entry and stop as soon as RUN is left.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("seq.pre_run_pulse", {2'b0, control_loop_pulse}, 3'd0);
    end
    chk("seq.run_entered", state_out, 3'd3);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("seq.run_loop_pulse k=%0d", k), {2'b0, control_loop_pulse},
          {2'b0, k inside {1, 9, 17}});
      chk($sformatf("seq.run_filter_pulse k=%0d", k), {2'b0, filter_pulse},
          {2'b0, k == 1});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("seq.stop_kills_pulse", {2'b0, control_loop_pulse}, 3'd0);
`endif

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 39) == 0),
           logic'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
